// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load-data select, r15 redirect,
// forwarding tap and retired-instruction counter.
module writeback_stage #(
    parameter logic [3:0] PC_REG = 4'hF,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic             in_byte,
    input  logic [3:0]       in_dest,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic             flush,
    output logic             write_en,
    output logic [3:0]       addr_3,
    output logic [31:0]      write_data,
    output logic             pc_write,
    output logic [31:0]      pc_target,
    output logic             fwd_valid,
    output logic [3:0]       fwd_addr,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] retired_count
);

    logic             valid_q;
    logic             reg_write_q;
    logic             mem_to_reg_q;
    logic             byte_sel_q;
    logic [3:0]       dest_q;
    logic [31:0]      alu_q;
    logic [31:0]      mem_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0]       lane_byte;
    logic [31:0]      result;
    logic             commit;
    logic             to_pc;

    // Fields load even on flush; only valid is killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            byte_sel_q   <= 1'b0;
            dest_q       <= 4'h0;
            alu_q        <= 32'h0;
            mem_q        <= 32'h0;
            cnt_q        <= '0;
        end else begin
            valid_q      <= in_valid & ~flush;
            reg_write_q  <= in_reg_write;
            mem_to_reg_q <= in_mem_to_reg;
            byte_sel_q   <= in_byte;
            dest_q       <= in_dest;
            alu_q        <= in_alu_result;
            mem_q        <= in_mem_data;
            if (valid_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        lane_byte = 8'h00;
        unique case (alu_q[1:0])
            2'd0: lane_byte = mem_q[7:0];
            2'd1: lane_byte = mem_q[15:8];
            2'd2: lane_byte = mem_q[23:16];
            2'd3: lane_byte = mem_q[31:24];
        endcase
    end

    always_comb begin
        result = alu_q;
        if (mem_to_reg_q) begin
            result = byte_sel_q ? {24'h0, lane_byte} : mem_q;
        end
    end

    assign commit        = valid_q & reg_write_q;
    assign to_pc         = (dest_q == PC_REG);

    assign write_en      = commit & ~to_pc;
    assign addr_3        = dest_q;
    assign write_data    = result;
    assign pc_write      = commit & to_pc;
    assign pc_target     = {result[31:2], 2'b00};
    assign fwd_valid     = write_en;
    assign fwd_addr      = dest_q;
    assign fwd_data      = result;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage: reset, ALU/load
// writeback, r15 redirect, flush/bubbles, async reset and counter wrap.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_byte;
    logic [3:0]  in_dest;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic        flush;

    logic        write_en, pc_write, fwd_valid;
    logic [3:0]  addr_3, fwd_addr;
    logic [31:0] write_data, pc_target, fwd_data;
    logic [31:0] retired_count;

    logic        w4_write_en, w4_pc_write, w4_fwd_valid;
    logic [3:0]  w4_addr_3, w4_fwd_addr;
    logic [31:0] w4_write_data, w4_pc_target, w4_fwd_data;
    logic [3:0]  w4_retired_count;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        pcw;
        logic [31:0] pct;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    logic        m_prev_valid;
    logic [31:0] m_cnt;

    writeback_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_byte(in_byte),
        .in_dest(in_dest), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .flush(flush),
        .write_en(write_en), .addr_3(addr_3), .write_data(write_data),
        .pc_write(pc_write), .pc_target(pc_target),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retired_count(retired_count)
    );

    writeback_stage #(.CNT_W(4)) u_w4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_byte(in_byte),
        .in_dest(in_dest), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .flush(flush),
        .write_en(w4_write_en), .addr_3(w4_addr_3),
        .write_data(w4_write_data),
        .pc_write(w4_pc_write), .pc_target(w4_pc_target),
        .fwd_valid(w4_fwd_valid), .fwd_addr(w4_fwd_addr),
        .fwd_data(w4_fwd_data),
        .retired_count(w4_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_cnt = 32'h0;
        sb.delete();
    endtask

    // Drive one instruction, predict what the write port shows after the
    // next edge, then compare once that edge has passed.
    task automatic step(input logic v, input logic rw, input logic m2r,
                        input logic byt, input logic [3:0] d,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic fl);
        exp_t        e;
        exp_t        g;
        logic [31:0] res;
        logic        live;
        @(negedge clk);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
        in_byte = byt; in_dest = d; in_alu_result = alu;
        in_mem_data = mem; flush = fl;
        if (!m2r)     res = alu;
        else if (!byt) res = mem;
        else          res = (mem >> (8 * alu[1:0])) & 32'hFF;
        if (m_prev_valid) m_cnt = m_cnt + 1;
        live = v & ~fl & rw;
        e.we   = live & (d != 4'hF);
        e.pcw  = live & (d == 4'hF);
        e.addr = d;
        e.data = res;
        e.pct  = res & 32'hFFFF_FFFC;
        e.cnt  = m_cnt;
        m_prev_valid = v & ~fl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("write_en",   {31'h0, write_en},  {31'h0, g.we});
        check("addr_3",     {28'h0, addr_3},    {28'h0, g.addr});
        check("write_data", write_data,         g.data);
        check("pc_write",   {31'h0, pc_write},  {31'h0, g.pcw});
        check("pc_target",  pc_target,          g.pct);
        check("fwd_valid",  {31'h0, fwd_valid}, {31'h0, g.we});
        check("fwd_addr",   {28'h0, fwd_addr},  {28'h0, g.addr});
        check("fwd_data",   fwd_data,           g.data);
        check("retired",    retired_count,      g.cnt);
        check("retired_w4", {28'h0, w4_retired_count},
              {28'h0, g.cnt[3:0]});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst = 1'b1;
        in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_byte = 0;
        in_dest = 0; in_alu_result = 0; in_mem_data = 0; flush = 0;

        // Reset held 50 ns under random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_reg_write = 1'($urandom);
            in_mem_to_reg = 1'($urandom); in_byte = 1'($urandom);
            in_dest = 4'($urandom); in_alu_result = $urandom;
            in_mem_data = $urandom; flush = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_write_en", {31'h0, write_en}, 32'h0);
            check("rst_pc_write", {31'h0, pc_write}, 32'h0);
            check("rst_write_data", write_data, 32'h0);
            check("rst_retired", retired_count, 32'h0);
        end
        @(negedge clk);
        in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_byte = 0;
        in_dest = 0; in_alu_result = 0; in_mem_data = 0; flush = 0;
        #2 rst = 1'b0;
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

        // ALU writeback, back to back
        step(1, 1, 0, 0, 4'h0, 32'h0000_01DA, 32'h0, 0);
        step(1, 1, 0, 0, 4'h1, 32'h0000_FFFF, 32'h0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        check("alu_count_2", retired_count, 32'd2);

        // Same dest twice: two separate writes
        step(1, 1, 0, 0, 4'h5, 32'h1111_1111, 32'h0, 0);
        step(1, 1, 0, 0, 4'h5, 32'h2222_2222, 32'h0, 0);

        // Word and byte loads
        step(1, 1, 1, 0, 4'hA, 32'h0000_0100, 32'h0A00_D3F1, 0);
        step(1, 1, 1, 1, 4'hA, 32'h0000_0100, 32'h0A00_D3F1, 0);
        check("byte_lane0", write_data, 32'h0000_00F1);
        step(1, 1, 1, 1, 4'hA, 32'h0000_0101, 32'h0A00_D3F1, 0);
        check("byte_lane1", write_data, 32'h0000_00D3);
        step(1, 1, 1, 1, 4'hA, 32'h0000_0102, 32'h0A00_D3F1, 0);
        check("byte_lane2", write_data, 32'h0000_0000);
        step(1, 1, 1, 1, 4'hA, 32'h0000_0103, 32'h0A00_D3F1, 0);
        check("byte_lane3", write_data, 32'h0000_000A);

        // r15 redirect, then byte load into r15
        step(1, 1, 0, 0, 4'hF, 32'h0000_1006, 32'h0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(1, 1, 1, 1, 4'hF, 32'h0000_0201, 32'h0A00_D3F1, 0);
        check("pc_byte", pc_target, 32'h0000_00D0);

        // Flushed instruction, invalid instruction with reg_write
        step(1, 1, 0, 0, 4'h3, 32'h0000_0033, 32'h0, 1);
        step(0, 1, 0, 0, 4'h4, 32'h0000_0044, 32'h0, 0);
        step(1, 0, 0, 0, 4'h6, 32'h0000_0066, 32'h0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

        // Async reset between edges while a write is live
        step(1, 1, 0, 0, 4'h7, 32'h0000_0777, 32'h0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_write_en", {31'h0, write_en}, 32'h0);
        check("async_retired", retired_count, 32'h0);
        check("async_write_data", write_data, 32'h0);
        model_reset();
        @(negedge clk);
        in_valid = 0; in_reg_write = 0; flush = 0;
        #2 rst = 1'b0;

        // 17 retirements through the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0, 0, 4'(i), 32'(i * 3), 32'h0, 0);
        end
        step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        check("wrap_w32", retired_count, 32'd17);
        check("wrap_w4", {28'h0, w4_retired_count}, 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register and result-select logic.
- Captures one instruction per cycle from the memory stage and selects the ALU result or load data (word or zero-extended byte).
- Drives the register file write port: write_en, addr_3, write_data.
- Writes to r15 are diverted to a PC-redirect output instead of the register file, because the register file's r15 is sourced externally.
- Also provides forwarding data to the execute stage and a retired-instruction counter.

Parameters:
- PC_REG, 4'hF: destination index treated as the program counter.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents a live instruction.
- in_reg_write  in  1  instruction writes a destination register.
- in_mem_to_reg  in  1  1 = result from in_mem_data, 0 = from in_alu_result.
- in_byte  in  1  byte load (only meaningful when in_mem_to_reg = 1).
- in_dest  in  4  destination register index.
- in_alu_result  in  32  ALU result; for loads, the effective address.
- in_mem_data  in  32  word read from data memory.
- flush  in  1  kill the instruction being captured this cycle.
- write_en  out  1  register file write enable.
- addr_3  out  4  register file write address.
- write_data  out  32  register file write data.
- pc_write  out  1  one-cycle pulse: instruction wrote r15.
- pc_target  out  32  redirect address, word-aligned.
- fwd_valid  out  1  forwarding data valid.
- fwd_addr  out  4  forwarded register index.
- fwd_data  out  32  forwarded value.
- retired_count  out  CNT_W  number of committed instructions.

Behaviour:
- Reset (async, immediate on rst = 1): all pipeline register fields cleared (valid, reg_write, mem_to_reg, byte, dest, alu_result, mem_data), retired_count = 0. Consequently write_en = 0, addr_3 = 0, write_data = 0, pc_write = 0, pc_target = 0, fwd_valid = 0, fwd_addr = 0, fwd_data = 0.
- Capture, each posedge with rst = 0:
  - flush = 1: valid <= 0; all other fields still load from inputs (don't-care).
  - otherwise: every field loads from its in_* input, and valid <= in_valid.
- Result select (combinational from registered fields):
  - mem_to_reg = 0: result = alu_result.
  - mem_to_reg = 1, byte = 0: result = mem_data.
  - mem_to_reg = 1, byte = 1: lane = alu_result[1:0] (little-endian); result = {24'h0, mem_data[8*lane+7 : 8*lane]}.
- Commit signals:
  - commit = valid & reg_write.
  - write_en = commit & (dest != PC_REG).
  - pc_write = commit & (dest == PC_REG).
  - pc_target = {result[31:2], 2'b00}.
  - addr_3 = dest, write_data = result; both are driven whenever the stage holds state, even when write_en = 0.
  - fwd_valid = write_en; fwd_addr = dest; fwd_data = result.
- Latency:
  - Inputs sampled at edge N appear on the write port during cycle N to N+1.
  - The register file stores the value at edge N+1.
  - With no new instruction, each output holds for exactly one cycle; the next edge loads the following instruction or a bubble.
- Counter: retired_count increments by 1 at each posedge where valid = 1, including instructions with reg_write = 0. It wraps modulo 2^CNT_W with no saturation.
- Boundary conditions:
  - Back-to-back instructions to the same dest: each writes in its own cycle; no merging.
  - in_valid = 0 with in_reg_write = 1: no write, no count.
  - flush and in_valid both 1: bubble; the flushed instruction is not counted.
  - Byte load into r15: pc_target is the zero-extended byte with bits [1:0] cleared.
  - rst asserted mid-cycle: outputs clear immediately without waiting for a clock edge. The first capture after release is the first posedge with rst = 0.

Test Plan:
- Reset: hold rst = 1 for 50 ns with random inputs -> write_en = 0, pc_write = 0, write_data = 0, retired_count = 0 throughout; deassert rst asynchronously -> outputs stay 0 until the first valid capture.
- ALU writeback: in_valid = 1, reg_write = 1, mem_to_reg = 0, dest = 0, alu = 0x000001DA; next cycle dest = 1, alu = 0x0000FFFF -> write_en = 1 for two consecutive cycles with (addr_3, write_data) = (0, 0x1DA) then (1, 0xFFFF); retired_count = 2.
- Loads: word load, dest = 0xA, mem_data = 0x0A00D3F1 -> write_data = 0x0A00D3F1. Byte loads with alu[1:0] = 0, 1, 2, 3 on the same word -> write_data = 0xF1, 0xD3, 0x00, 0x0A.
- PC write: dest = 0xF, alu = 0x00001006 -> pc_write = 1 for one cycle, pc_target = 0x00001004, write_en = 0, fwd_valid = 0.
- Flush and bubbles: valid instruction to dest = 3 presented with flush = 1 -> no write_en, no pc_write, count unchanged. in_valid = 0 with reg_write = 1 -> no write, no count.
- Async reset mid-stream: assert rst between clock edges while write_en = 1 -> write_en and retired_count go to 0 before the next edge. Counter wrap with CNT_W = 4: 17 valid instructions -> retired_count = 1.
